// File: rtl/mips32_prog_loader_pkg.sv
// mips32_prog_loader_pkg
//   Shared definitions for the MIPS32 program loader.
//   - state_t : loader FSM state encoding
//   - HDR_*   : bit positions of the header word fields
//               [31:16] base word address, [15] go, [14:0] payload word count
package mips32_prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int HDR_BASE_MSB = 31;
   localparam int HDR_BASE_LSB = 16;
   localparam int HDR_GO_BIT   = 15;
   localparam int HDR_CNT_MSB  = 14;
   localparam int HDR_CNT_LSB  = 0;
   localparam int HDR_CNT_W    = HDR_CNT_MSB - HDR_CNT_LSB + 1;

endpackage

// File: rtl/mips32_prog_loader_if.sv
// mips32_prog_loader_if
//   Bundles the loader's word-stream input and its memory write port.
//   Signals:
//     in_valid / in_ready / in_data   word stream (accept = in_valid & in_ready)
//     mem_we / mem_addr / mem_wdata   write port into the CPU's unified memory
//   Modports:
//     master : stream source / memory side
//     slave  : the loader itself
interface mips32_prog_loader_if #(
   parameter int AW = 10
);
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_data;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mips32_prog_loader_run_counter.sv
// mips32_prog_loader_run_counter
//   Run-cycle counter that saturates at MAX_CYCLES.
//   Ports:
//     clk1        clock (rising edge)
//     rst         synchronous active-high reset, clears the count
//     clear_i     synchronous clear (priority over enable)
//     enable_i    count one cycle
//     count_o     current count
//     limit_hit_o this enabled cycle brings the count to MAX_CYCLES
module mips32_prog_loader_run_counter #(
   parameter int CW         = 32,
   parameter int MAX_CYCLES = 4096
) (
   input  logic          clk1,
   input  logic          rst,
   input  logic          clear_i,
   input  logic          enable_i,
   output logic [CW-1:0] count_o,
   output logic          limit_hit_o
);

   localparam logic [CW-1:0] LIMIT = CW'(MAX_CYCLES);
   localparam logic [CW-1:0] LAST  = CW'(MAX_CYCLES - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != LIMIT)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Flags the cycle whose increment lands exactly on the limit.
   assign limit_hit_o = enable_i && !clear_i && (count_q == LAST);
   assign count_o     = count_q;

endmodule

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader
//   Boot stage for pipe_MIPS32: takes header/payload word frames, writes the
//   payload into the CPU's unified memory, then releases and starts the CPU and
//   times its run until it halts or hits MAX_CYCLES.
//   Ports:
//     clk1         clock (rising edge)
//     rst          synchronous active-high reset (aborts any frame / run)
//     bus          word stream in + memory write port (slave modport)
//     cpu_hold     CPU held while idle/loading
//     cpu_start    one-cycle start pulse
//     cpu_pc_init  start PC presented with cpu_start
//     cpu_halted   CPU executed HLT (only looked at while running)
//     done         run finished; held until the next header
//     timeout      run ended on the cycle limit
//     cycle_count  cycles from cpu_start to halt/timeout
module mips32_prog_loader
   import mips32_prog_loader_pkg::*;
#(
   parameter int AW         = 10,
   parameter int CW         = 32,
   parameter int MAX_CYCLES = 4096
) (
   input  logic                 clk1,
   input  logic                 rst,
   mips32_prog_loader_if.slave  bus,
   output logic                 cpu_hold,
   output logic                 cpu_start,
   output logic [AW-1:0]        cpu_pc_init,
   input  logic                 cpu_halted,
   output logic                 done,
   output logic                 timeout,
   output logic [CW-1:0]        cycle_count
);

   state_t                 state_q,     state_d;
   logic [AW-1:0]          addr_q,      addr_d;
   logic [HDR_CNT_W-1:0]   rem_q,       rem_d;
   logic                   go_q,        go_d;
   logic [AW-1:0]          pc_q,        pc_d;
   logic                   first_q,     first_d;
   logic                   timeout_q,   timeout_d;
   logic                   mem_we_q,    mem_we_d;
   logic [AW-1:0]          mem_addr_q,  mem_addr_d;
   logic [31:0]            mem_wdata_q, mem_wdata_d;

   logic                   in_ready;
   logic                   accept;
   logic [AW-1:0]          hdr_base;
   logic                   hdr_go;
   logic [HDR_CNT_W-1:0]   hdr_cnt;
   logic                   cnt_clear;
   logic                   cnt_en;
   logic                   limit_hit;

   assign in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DONE);
   assign accept   = bus.in_valid && in_ready;

   // Only the low AW bits of the base field address the memory.
   assign hdr_base = bus.in_data[HDR_BASE_LSB +: AW];
   assign hdr_go   = bus.in_data[HDR_GO_BIT];
   assign hdr_cnt  = bus.in_data[HDR_CNT_MSB:HDR_CNT_LSB];

   mips32_prog_loader_run_counter #(
      .CW         (CW),
      .MAX_CYCLES (MAX_CYCLES)
   ) u_run_counter (
      .clk1        (clk1),
      .rst         (rst),
      .clear_i     (cnt_clear),
      .enable_i    (cnt_en),
      .count_o     (cycle_count),
      .limit_hit_o (limit_hit)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      go_d        = go_q;
      pc_d        = pc_q;
      first_d     = first_q;
      timeout_d   = timeout_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cnt_clear   = 1'b0;
      cnt_en      = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               addr_d    = hdr_base;
               rem_d     = hdr_cnt;
               go_d      = hdr_go;
               timeout_d = 1'b0;
               cnt_clear = 1'b1;
               // The start PC comes from the first frame of each program.
               if (first_q) begin
                  pc_d    = hdr_base;
                  first_d = 1'b0;
               end
               if (hdr_cnt != '0) begin
                  state_d = ST_LOAD;
               end else if (hdr_go) begin
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_LOAD: begin
            if (accept) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = bus.in_data;
               addr_d      = addr_q + 1'b1;
               rem_d       = rem_q - 1'b1;
               if (rem_q == HDR_CNT_W'(1)) begin
                  state_d = go_q ? ST_START : ST_IDLE;
               end
            end
         end

         ST_START: begin
            cnt_clear = 1'b1;
            state_d   = ST_RUN;
         end

         ST_RUN: begin
            cnt_en = 1'b1;
            // Halt is checked first so it wins when it coincides with the limit.
            if (cpu_halted) begin
               state_d = ST_DONE;
               first_d = 1'b1;
            end else if (limit_hit) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
               first_d   = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         go_q        <= 1'b0;
         pc_q        <= '0;
         first_q     <= 1'b1;
         timeout_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         go_q        <= go_d;
         pc_q        <= pc_d;
         first_q     <= first_d;
         timeout_q   <= timeout_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   assign cpu_hold    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign cpu_start   = (state_q == ST_START);
   assign cpu_pc_init = pc_q;
   assign done        = (state_q == ST_DONE);
   assign timeout     = timeout_q;

endmodule
